bluespec_sized_fifo: RTL and testbench
======================================

Name: bluespec_sized_fifo

Overview:
Parametrised-depth synchronous FIFO with Bluespec-style ready/enable handshake. It is the generalised successor to the fixed depth-2 FIFO used in the RoCEv2 datapath.
- Register-array storage with circular read/write pointers.
- Registered full/empty/almost-full flags, an occupancy count, and sticky protocol-error flags.
- Drop-in for deeper elastic buffers between RoCEv2 pipeline stages.

Parameters:
WIDTH, 1, data width in bits (>=1)
DEPTH, 4, number of entries (>=2; need not be a power of 2)
AFULL_LVL, DEPTH-1, COUNT at or above which ALMOST_FULL_N deasserts (1..DEPTH)
GUARDED, 1, 1 = ENQ while full is illegal even with DEQ; 0 = ENQ+DEQ while full is legal

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  asynchronous, active-low reset
D_IN  in  WIDTH  enqueue data
ENQ  in  1  enqueue strobe
FULL_N  out  1  1 = space available
D_OUT  out  WIDTH  head entry (valid when EMPTY_N=1)
DEQ  in  1  dequeue strobe
EMPTY_N  out  1  1 = data available
CLR  in  1  synchronous clear
COUNT  out  $clog2(DEPTH+1)  occupancy
ALMOST_FULL_N  out  1  0 when COUNT >= AFULL_LVL
ENQ_ERR  out  1  sticky: illegal enqueue seen
DEQ_ERR  out  1  sticky: illegal dequeue seen

Behaviour:
- Reset (RST=0, asynchronous assert, synchronous-safe release) sets:
  - EMPTY_N=0, FULL_N=1, COUNT=0, ALMOST_FULL_N=1 (0 if AFULL_LVL=0 is forbidden; AFULL_LVL>=1)
  - ENQ_ERR=0, DEQ_ERR=0, rd_ptr=wr_ptr=0
- CLR=1 (RST=1): same state as reset on the next edge. CLR has priority over ENQ/DEQ; strobes in that cycle are discarded.
- Legal enqueue (le): ENQ=1 and (FULL_N=1, or GUARDED=0 with DEQ=1 and EMPTY_N=1).
  - Writes mem[wr_ptr]=D_IN.
  - wr_ptr advances; it wraps from DEPTH-1 to 0.
- Legal dequeue (ld): DEQ=1 and EMPTY_N=1.
  - rd_ptr advances with the same wrap rule.
- COUNT_next = COUNT + le - ld.
- Flags are registered and derived from COUNT_next:
  - EMPTY_N = (COUNT_next != 0)
  - FULL_N = (COUNT_next != DEPTH)
  - ALMOST_FULL_N = (COUNT_next < AFULL_LVL)
- D_OUT = mem[rd_ptr]. Latency from enqueue into an empty FIFO to EMPTY_N=1 and valid D_OUT is 1 cycle. No bypass.
- Simultaneous ENQ+DEQ:
  - Partially filled FIFO: both occur, COUNT unchanged.
  - Empty FIFO: enqueue only, DEQ_ERR set.
  - Full FIFO, GUARDED=1: dequeue only, ENQ dropped, ENQ_ERR set.
  - Full FIFO, GUARDED=0: both occur, COUNT stays DEPTH.
- ENQ while full, without DEQ: dropped, ENQ_ERR set. Contents unchanged.
- DEQ while empty: ignored, DEQ_ERR set.
- Error flags clear only on reset or CLR.
- Reset asserted mid-operation: flags, pointers and COUNT return to reset values immediately. Storage contents are undefined unless the optional feature is compiled in.
- Simulation-only $display warnings mirror ENQ_ERR/DEQ_ERR events.

Optional Feature:
BLUESPEC_FIFO_RESET_STORAGE_EN
- Defined: reset and CLR also zero every storage entry, so D_OUT=0 after reset or clear.
- Undefined: storage has no reset. D_OUT after reset or clear is the stale mem[0], and flags alone indicate validity. Saves reset fan-out.

Test Plan:
- DEPTH=4: enqueue 0xA1,0xA2,0xA3,0xA4 on consecutive cycles.
  - FULL_N=0 after the 4th edge, COUNT=4, ALMOST_FULL_N=0 at COUNT=3.
  - Then dequeue 4 times: D_OUT reads A1..A4 in order, EMPTY_N=0, COUNT=0.
- DEPTH=3 wrap: 10 cycles of continuous ENQ+DEQ after one priming enqueue. Data order preserved across pointer wrap, COUNT stays 1, no error flags.
- DEPTH=4 full, GUARDED=1, ENQ+DEQ with D_IN=0x55.
  - Head dequeued, COUNT=3, 0x55 absent, ENQ_ERR=1.
  - Same case with GUARDED=0: COUNT=4, 0x55 appears as the last element, ENQ_ERR=0.
- Empty FIFO, ENQ+DEQ with D_IN=0x77: COUNT=1, D_OUT=0x77, DEQ_ERR=1. Then CLR=1 for 1 cycle: COUNT=0, EMPTY_N=0, DEQ_ERR=0.
- Fill to COUNT=3 with ENQ held, assert RST=0 asynchronously mid-cycle.
  - Outputs reach reset values before the next edge: EMPTY_N=0, FULL_N=1, COUNT=0.
  - With BLUESPEC_FIFO_RESET_STORAGE_EN, D_OUT=0.
- CLR and ENQ asserted together on a FIFO with COUNT=2: next cycle COUNT=0 and the enqueued word is discarded.

Source files
------------

// File: rtl/bluespec_sized_fifo.sv
// Parametrised-depth synchronous FIFO with Bluespec-style ready/enable handshake.
// Optional macro BLUESPEC_FIFO_RESET_STORAGE_EN: reset and CLR also zero the storage array.
module bluespec_sized_fifo #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_LVL = DEPTH - 1,
    parameter bit          GUARDED   = 1'b1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [WIDTH-1:0]               D_IN,
    input  logic                           ENQ,
    output logic                           FULL_N,
    output logic [WIDTH-1:0]               D_OUT,
    input  logic                           DEQ,
    output logic                           EMPTY_N,
    input  logic                           CLR,
    output logic [$clog2(DEPTH+1)-1:0]     COUNT,
    output logic                           ALMOST_FULL_N,
    output logic                           ENQ_ERR,
    output logic                           DEQ_ERR
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_n_q, empty_n_d;
    logic             full_n_q, full_n_d;
    logic             afull_n_q, afull_n_d;
    logic             enq_err_q, enq_err_d;
    logic             deq_err_q, deq_err_d;
    logic             enq_ok, deq_ok;

    // Legal strobes; a clear in the same cycle discards both.
    always_comb begin
        enq_ok = 1'b0;
        deq_ok = 1'b0;
        if (!CLR) begin
            deq_ok = DEQ && empty_n_q;
            enq_ok = ENQ && (full_n_q || (!GUARDED && DEQ && empty_n_q));
        end
    end

    // Next-state: pointers, occupancy, flags derived from the next count.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        enq_err_d = enq_err_q;
        deq_err_d = deq_err_q;
        if (CLR) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            enq_err_d = 1'b0;
            deq_err_d = 1'b0;
        end else begin
            if (enq_ok) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (deq_ok) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            count_d   = count_q + CW'(enq_ok) - CW'(deq_ok);
            enq_err_d = enq_err_q || (ENQ && !enq_ok);
            deq_err_d = deq_err_q || (DEQ && !deq_ok);
        end
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CW'(DEPTH));
        afull_n_d = (count_d < CW'(AFULL_LVL));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            afull_n_q <= 1'b1;
            enq_err_q <= 1'b0;
            deq_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            afull_n_q <= afull_n_d;
            enq_err_q <= enq_err_d;
            deq_err_q <= deq_err_d;
        end
    end

`ifdef BLUESPEC_FIFO_RESET_STORAGE_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_q <= '{default: '0};
        end else if (CLR) begin
            mem_q <= '{default: '0};
        end else if (enq_ok) begin
            mem_q[wr_ptr_q] <= D_IN;
        end
    end
`else
    // Storage has no reset; flags alone qualify D_OUT.
    always_ff @(posedge CLK) begin
        if (enq_ok) begin
            mem_q[wr_ptr_q] <= D_IN;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (RST && !CLR && ENQ && !enq_ok) begin
            $display("%m: warning, illegal enqueue dropped at %0t", $time);
        end
        if (RST && !CLR && DEQ && !deq_ok) begin
            $display("%m: warning, illegal dequeue ignored at %0t", $time);
        end
    end
`endif

    assign FULL_N        = full_n_q;
    assign EMPTY_N       = empty_n_q;
    assign ALMOST_FULL_N = afull_n_q;
    assign COUNT         = count_q;
    assign ENQ_ERR       = enq_err_q;
    assign DEQ_ERR       = deq_err_q;
    assign D_OUT         = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bluespec_sized_fifo.sv
// Scoreboard bench: three FIFO configurations driven with shared stimulus,
// each compared every cycle against a queue-based reference model.
module tb_bluespec_sized_fifo;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enq = 1'b0, deq = 1'b0, clr = 1'b0;
    logic [7:0] din = '0;

    logic [7:0] dout_w  [3];
    logic [2:0] cnt_w   [3];
    logic [1:0] cnt2;
    logic       full_w  [3];
    logic       empty_w [3];
    logic       afull_w [3];
    logic       eerr_w  [3];
    logic       derr_w  [3];

    int n_checks = 0;
    int n_fail   = 0;

    bq_t mq [3];
    int  m_depth [3] = '{4, 4, 3};
    bit  m_guard [3] = '{1'b1, 1'b0, 1'b1};
    int  m_afull [3] = '{3, 3, 2};
    bit  m_eerr  [3] = '{1'b0, 1'b0, 1'b0};
    bit  m_derr  [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    bluespec_sized_fifo #(.WIDTH(8), .DEPTH(4), .GUARDED(1'b1)) u0 (
        .CLK(clk), .RST(rst_n), .D_IN(din), .ENQ(enq), .FULL_N(full_w[0]),
        .D_OUT(dout_w[0]), .DEQ(deq), .EMPTY_N(empty_w[0]), .CLR(clr),
        .COUNT(cnt_w[0]), .ALMOST_FULL_N(afull_w[0]), .ENQ_ERR(eerr_w[0]), .DEQ_ERR(derr_w[0]));

    bluespec_sized_fifo #(.WIDTH(8), .DEPTH(4), .GUARDED(1'b0)) u1 (
        .CLK(clk), .RST(rst_n), .D_IN(din), .ENQ(enq), .FULL_N(full_w[1]),
        .D_OUT(dout_w[1]), .DEQ(deq), .EMPTY_N(empty_w[1]), .CLR(clr),
        .COUNT(cnt_w[1]), .ALMOST_FULL_N(afull_w[1]), .ENQ_ERR(eerr_w[1]), .DEQ_ERR(derr_w[1]));

    bluespec_sized_fifo #(.WIDTH(8), .DEPTH(3), .GUARDED(1'b1)) u2 (
        .CLK(clk), .RST(rst_n), .D_IN(din), .ENQ(enq), .FULL_N(full_w[2]),
        .D_OUT(dout_w[2]), .DEQ(deq), .EMPTY_N(empty_w[2]), .CLR(clr),
        .COUNT(cnt2), .ALMOST_FULL_N(afull_w[2]), .ENQ_ERR(eerr_w[2]), .DEQ_ERR(derr_w[2]));

    assign cnt_w[2] = {1'b0, cnt2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one FIFO over one clock edge.
    task automatic model_step(input int i, input bit e, input bit d, input bit c, input logic [7:0] v);
        bit full, empty, le, ld;
        if (c) begin
            mq[i].delete();
            m_eerr[i] = 1'b0;
            m_derr[i] = 1'b0;
        end else begin
            empty = (mq[i].size() == 0);
            full  = (mq[i].size() == m_depth[i]);
            ld    = d && !empty;
            le    = e && (!full || (!m_guard[i] && d && !empty));
            if (e && !le) m_eerr[i] = 1'b1;
            if (d && !ld) m_derr[i] = 1'b1;
            if (ld) void'(mq[i].pop_front());
            if (le) mq[i].push_back(v);
        end
    endtask

    task automatic check_all();
        int sz;
        for (int i = 0; i < 3; i++) begin
            sz = mq[i].size();
            check($sformatf("u%0d count", i), 32'(cnt_w[i]), 32'(sz));
            check($sformatf("u%0d empty_n", i), 32'(empty_w[i]), 32'(sz != 0));
            check($sformatf("u%0d full_n", i), 32'(full_w[i]), 32'(sz != m_depth[i]));
            check($sformatf("u%0d almost_full_n", i), 32'(afull_w[i]), 32'(sz < m_afull[i]));
            check($sformatf("u%0d enq_err", i), 32'(eerr_w[i]), 32'(m_eerr[i]));
            check($sformatf("u%0d deq_err", i), 32'(derr_w[i]), 32'(m_derr[i]));
            if (sz > 0) check($sformatf("u%0d d_out", i), 32'(dout_w[i]), 32'(mq[i][0]));
        end
    endtask

    task automatic drive(input bit e, input bit d, input bit c, input logic [7:0] v);
        enq = e;
        deq = d;
        clr = c;
        din = v;
        for (int i = 0; i < 3; i++) model_step(i, e, d, c, v);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_values(input string phase);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s u%0d count", phase, i), 32'(cnt_w[i]), 32'd0);
            check($sformatf("%s u%0d empty_n", phase, i), 32'(empty_w[i]), 32'd0);
            check($sformatf("%s u%0d full_n", phase, i), 32'(full_w[i]), 32'd1);
            check($sformatf("%s u%0d almost_full_n", phase, i), 32'(afull_w[i]), 32'd1);
            check($sformatf("%s u%0d enq_err", phase, i), 32'(eerr_w[i]), 32'd0);
            check($sformatf("%s u%0d deq_err", phase, i), 32'(derr_w[i]), 32'd0);
`ifdef BLUESPEC_FIFO_RESET_STORAGE_EN
            check($sformatf("%s u%0d d_out", phase, i), 32'(dout_w[i]), 32'd0);
`endif
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        // Fill then drain in order.
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0, 8'hA1 + 8'(k));
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h00);

        // Continuous enqueue+dequeue across pointer wrap.
        drive(1'b1, 1'b0, 1'b0, 8'h10);
        for (int k = 1; k <= 10; k++) drive(1'b1, 1'b1, 1'b0, 8'h10 + 8'(k));
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h00);

        // Full FIFO with simultaneous enqueue+dequeue, then drain.
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0, 8'hB1 + 8'(k));
        drive(1'b1, 1'b1, 1'b0, 8'h55);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h00);

        // Empty FIFO with simultaneous strobes, then clear.
        drive(1'b1, 1'b1, 1'b0, 8'h77);
        drive(1'b0, 1'b0, 1'b1, 8'h00);

        // Clear beats a concurrent enqueue.
        drive(1'b1, 1'b0, 1'b0, 8'hC1);
        drive(1'b1, 1'b0, 1'b0, 8'hC2);
        drive(1'b1, 1'b0, 1'b1, 8'hC3);
        drive(1'b1, 1'b0, 1'b0, 8'hC4);
        drive(1'b0, 1'b1, 1'b0, 8'h00);

        // Random traffic with occasional clears.
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 24) == 0), 8'($urandom));
        end

        // Asynchronous reset mid-cycle while enqueue is held.
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 8'hD1 + 8'(k));
        enq = 1'b1;
        din = 8'hEE;
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            m_eerr[i] = 1'b0;
            m_derr[i] = 1'b0;
        end
        enq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all();
        drive(1'b1, 1'b0, 1'b0, 8'h3C);
        drive(1'b0, 1'b1, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
